// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: fetch-stage branch predictor built from a PHT of
// saturating counters and a direct-mapped BTB, both held in registers.
// Lookups are combinational and updates come from the resolve stage.
// After reset a sweep clears the tables, one PHT entry per cycle, and then
// raises ready.
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// the PHT index (gshare). When it is undefined the predictor is bimodal.
module branch_predictor_gshare #(
    parameter int unsigned PHT_ENTRIES = 1024,
    parameter int unsigned CTR_W       = 2,
    parameter int unsigned CTR_INIT    = 1,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned GHR_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    output logic        btb_hit,
    output logic        ready,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned PIDX  = $clog2(PHT_ENTRIES);
    localparam int unsigned BIDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - BIDX - 2;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state;
    logic [PIDX-1:0]   sweep_idx;

    logic [CTR_W-1:0]  pht        [PHT_ENTRIES];
    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [31:0]       btb_target [BTB_ENTRIES];

    logic [PIDX-1:0]   hist;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]  ghr;
    assign hist = PIDX'(ghr);
`else
    assign hist = '0;
`endif

    // The two low PC bits are always zero for aligned instructions.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], upd_pc[1:0]};

    logic [PIDX-1:0]   lk_pidx;
    logic [BIDX-1:0]   lk_bidx;
    logic [TAG_W-1:0]  lk_tag;
    logic [PIDX-1:0]   up_pidx;
    logic [BIDX-1:0]   up_bidx;
    logic [TAG_W-1:0]  up_tag;
    logic              upd_en;
    logic [CTR_W-1:0]  upd_ctr;
    logic [CTR_W-1:0]  upd_ctr_next;

    assign lk_pidx = pc[PIDX+1:2] ^ hist;
    assign lk_bidx = pc[BIDX+1:2];
    assign lk_tag  = pc[31:BIDX+2];
    assign up_pidx = upd_pc[PIDX+1:2] ^ hist;
    assign up_bidx = upd_pc[BIDX+1:2];
    assign up_tag  = upd_pc[31:BIDX+2];
    assign upd_en  = upd_valid & ready & ~reset;

    // Zero-latency lookup. The tables are read before this cycle's update, so there is no bypass.
    always_comb begin
        btb_hit    = ready & btb_valid[lk_bidx] & (btb_tag[lk_bidx] == lk_tag);
        pred_taken = btb_hit & pht[lk_pidx][CTR_W-1];
        pred_pc    = pred_taken ? btb_target[lk_bidx] : pc + 32'd4;
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        upd_ctr      = pht[up_pidx];
        upd_ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != '1) upd_ctr_next = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_ctr_next = upd_ctr - 1'b1;
        end
    end

    // Control FSM: clear sweep, then READY with ready registered. History shifts on accepted updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            ready     <= 1'b0;
`ifdef BP_GSHARE_EN
            ghr       <= '0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == PIDX'(PHT_ENTRIES - 1)) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
                end
                ST_READY: begin
`ifdef BP_GSHARE_EN
                    if (upd_en) ghr <= {ghr[GHR_W-2:0], upd_taken};
`endif
                end
                default: begin
                    state <= ST_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Table writes: the sweep owns the write port during INIT, and trained updates own it during READY.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_INIT) begin
            pht[sweep_idx] <= CTR_W'(CTR_INIT);
            if (32'(sweep_idx) < BTB_ENTRIES)
                btb_valid[sweep_idx[BIDX-1:0]] <= 1'b0;
        end else if (upd_en) begin
            pht[up_pidx] <= upd_ctr_next;
            if (upd_taken) begin
                btb_valid[up_bidx]  <= 1'b1;
                btb_tag[up_bidx]    <= up_tag;
                btb_target[up_bidx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare with default parameters.
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        btb_hit;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pred_taken (pred_taken),
        .pred_pc    (pred_pc),
        .btb_hit    (btb_hit),
        .ready      (ready),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        et;
        logic        eh;
        logic [31:0] epc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge and check the pre-update lookup. The update lands on the next rising edge.
    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        pc = v.pc; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
        #1;
        chk({name, ".pred_taken"}, 32'(pred_taken), 32'(v.et));
        chk({name, ".btb_hit"},    32'(btb_hit),    32'(v.eh));
        chk({name, ".pred_pc"},    pred_pc,         v.epc);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.ready",      32'(ready),      32'd0);
        chk("rst.pred_taken", 32'(pred_taken), 32'd0);
        chk("rst.btb_hit",    32'(btb_hit),    32'd0);
        chk("rst.pred_pc",    pred_pc,         pc + 32'd4);
        reset = 1'b0;
    endtask

    // Count rising edges until ready is seen (0 if not within limit). Also count any live prediction seen while not ready.
    task automatic sweep(input int limit, output int n, output int bad);
        n = 0;
        bad = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            #1;
            if (ready) begin
                n = k;
                break;
            end
            if (pred_taken !== 1'b0 || btb_hit !== 1'b0 || pred_pc !== pc + 32'd4) bad++;
        end
    endtask

    vec_t tbl[23];
    int   n_cyc;
    int   n_bad;

    initial begin
        // Bimodal training, saturation, aliasing, wrap and ignored updates.
        tbl[0]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h104};
        tbl[1]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[2]  = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
        tbl[3]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[4]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[5]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[6]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[7]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
        tbl[8]  = '{32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
        tbl[9]  = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
        tbl[10] = '{32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
        tbl[11] = '{32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104};
        tbl[12] = '{32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104};
        tbl[13] = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h104};
        tbl[14] = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h104};
        tbl[15] = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
        tbl[16] = '{32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h204};
        tbl[17] = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104};
        tbl[18] = '{32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h300};
        tbl[19] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        tbl[20] = '{32'h200, 1'b0, 32'h200, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300};
        tbl[21] = '{32'h200, 1'b0, 32'h200, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300};
        tbl[22] = '{32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h300};

        reset = 1'b0; pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

        // Reset, then sweep with a taken update held on the port that must be ignored.
        apply_reset;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
        sweep(1100, n_cyc, n_bad);
        upd_valid = 1'b0;
        chk("init.sweep_len", 32'(n_cyc), 32'd1024);
        chk("init.quiet",     32'(n_bad), 32'd0);
        #1;
        chk("post_init.btb_hit",    32'(btb_hit),    32'd0);
        chk("post_init.pred_taken", 32'(pred_taken), 32'd0);
        chk("post_init.pred_pc",    pred_pc,         32'h104);

`ifdef BP_GSHARE_EN
        // T,T,N at 0x40 walk indices 0x10, 0x11, 0x13, leaving GHR=0b110. Lookup 0x40 then reads index 0x16, which still holds 1.
        apply_vec('{32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h44}, "gs_t1");
        apply_vec('{32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h44}, "gs_t2");
        apply_vec('{32'h40, 1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b1, 32'h44}, "gs_n3");
        apply_vec('{32'h40, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'h44}, "gs_idx16");
        apply_vec('{32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h44}, "gs_same_cycle");
`else
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));
`endif
        @(negedge clk);
        upd_valid = 1'b0; pc = 32'h100;

        // Reset from READY, abort the sweep midway, then run a full sweep.
        apply_reset;
        sweep(500, n_cyc, n_bad);
        chk("mid.not_ready", 32'(n_cyc), 32'd0);
        apply_reset;
        sweep(1100, n_cyc, n_bad);
        chk("resweep.len",   32'(n_cyc), 32'd1024);
        chk("resweep.quiet", 32'(n_bad), 32'd0);

        apply_vec('{32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204}, "clr_200");
        apply_vec('{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h104}, "clr_100");
`ifdef BP_GSHARE_EN
        // GHR is 1 after that update, so 0x100 indexes the untouched 0x41.
        apply_vec('{32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h104}, "clr_ctr1");
`else
        // The counter was re-initialised to 1. One taken update makes it 2, so the lookup predicts taken.
        apply_vec('{32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200}, "clr_ctr1");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
